// File: rtl/full_sub_pkg.sv
// Shared constants for the full subtractor slice.
package full_sub_pkg;
    localparam bit REG_OUT_DEFAULT = 1'b1;
endpackage

// File: rtl/full_sub_if.sv
// Operand/result bundle between the full subtractor and whoever drives it.
interface full_sub_if;
    logic a;
    logic b;
    logic c;
    logic en;
    logic ser;
    logic sof;
    logic d;
    logic bo;
    logic d_q;
    logic bo_q;
    logic vld;

    modport master (
        output a, b, c, en, ser, sof,
        input  d, bo, d_q, bo_q, vld
    );

    modport slave (
        input  a, b, c, en, ser, sof,
        output d, bo, d_q, bo_q, vld
    );
endinterface

// File: rtl/full_sub_cell.sv
// Pure combinational one-bit full subtractor: a - b - bin.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bin;
    assign bo = (~a & (b | bin)) | (b & bin);
endmodule

// File: rtl/full_sub.sv
// One-bit full subtractor with optional registered outputs and an internal
// borrow register that chains bits when operating bit-serially, LSB first.
module full_sub
    import full_sub_pkg::*;
#(
    parameter bit REG_OUT = REG_OUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    full_sub_if.slave  bus
);
    logic bin;
    logic d_cmb;
    logic bo_cmb;
    logic brg_reg;
    logic vld_reg;

    // brg only reaches bin through a register, so there is no loop back from bo.
    assign bin = (bus.ser && !bus.sof) ? brg_reg : bus.c;

    full_sub_cell u_cell (
        .a   (bus.a),
        .b   (bus.b),
        .bin (bin),
        .d   (d_cmb),
        .bo  (bo_cmb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brg_reg <= 1'b0;
            vld_reg <= 1'b0;
        end else begin
            vld_reg <= bus.en;
            if (bus.en) begin
                brg_reg <= bo_cmb;
            end
        end
    end

    assign bus.d   = d_cmb;
    assign bus.bo  = bo_cmb;
    assign bus.vld = vld_reg;

    generate
        if (REG_OUT) begin : g_reg_out
            logic d_q_reg;
            logic bo_q_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_q_reg  <= 1'b0;
                    bo_q_reg <= 1'b0;
                end else if (bus.en) begin
                    d_q_reg  <= d_cmb;
                    bo_q_reg <= bo_cmb;
                end
            end

            assign bus.d_q  = d_q_reg;
            assign bus.bo_q = bo_q_reg;
        end else begin : g_comb_out
            assign bus.d_q  = d_cmb;
            assign bus.bo_q = bo_cmb;
        end
    endgenerate
endmodule

// File: tb/tb_full_sub.sv
// Bench for full_sub: truth-table and serial-word vectors, scoreboarded
// registered outputs, async reset, mode switching and the unregistered build.
module tb_full_sub;
    logic clk;
    logic rst_n;

    full_sub_if bus ();
    full_sub_if bus0 ();

    full_sub #(.REG_OUT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    full_sub #(.REG_OUT(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic en;
        logic ser;
        logic sof;
        logic exp_d;
        logic exp_bo;
    } vec_t;

    typedef struct {
        logic d;
        logic bo;
    } exp_t;

    vec_t tbl [16];
    exp_t sb_q [$];

    int   n_vec = 0;
    int   n_err = 0;
    logic brg_m = 1'b0;
    logic vld_m = 1'b0;
    logic dq_m  = 1'b0;
    logic boq_m = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clocked transaction on the registered DUT, checked against the bench model.
    task automatic cycle(input logic a, input logic b, input logic c, input logic en,
                         input logic ser, input logic sof, input string tag,
                         output logic act_d, output logic act_bo);
        logic       bin;
        logic [1:0] r;
        exp_t       e;
        bus.a = a; bus.b = b; bus.c = c; bus.en = en; bus.ser = ser; bus.sof = sof;
        bin = (ser && !sof) ? brg_m : c;
        r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
        #2;
        act_d  = bus.d;
        act_bo = bus.bo;
        check({tag, " d"}, bus.d, r[0]);
        check({tag, " bo"}, bus.bo, r[1]);
        if (en) sb_q.push_back('{d: r[0], bo: r[1]});
        @(posedge clk);
        if (en) begin
            brg_m = r[1];
            dq_m  = r[0];
            boq_m = r[1];
        end
        vld_m = en;
        #1;
        check({tag, " vld"}, bus.vld, vld_m);
        if (vld_m) begin
            if (sb_q.size() == 0) begin
                check({tag, " scoreboard empty"}, 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check({tag, " d_q"}, bus.d_q, e.d);
                check({tag, " bo_q"}, bus.bo_q, e.bo);
            end
        end else begin
            check({tag, " d_q hold"}, bus.d_q, dq_m);
            check({tag, " bo_q hold"}, bus.bo_q, boq_m);
        end
        $display("txn %-14s a=%b b=%b c=%b en=%b ser=%b sof=%b -> d=%b bo=%b d_q=%b bo_q=%b vld=%b",
                 tag, a, b, c, en, ser, sof, act_d, act_bo, bus.d_q, bus.bo_q, bus.vld);
    endtask

    logic ad;
    logic abo;

    initial begin
        // Truth table, ser=0: {a,b,c,en,ser,sof,d,bo}
        tbl[0]  = {6'b000_100, 2'b00};
        tbl[1]  = {6'b001_100, 2'b11};
        tbl[2]  = {6'b010_100, 2'b11};
        tbl[3]  = {6'b011_100, 2'b01};
        tbl[4]  = {6'b100_100, 2'b10};
        tbl[5]  = {6'b101_100, 2'b00};
        tbl[6]  = {6'b110_100, 2'b00};
        tbl[7]  = {6'b111_100, 2'b11};
        // Serial 5-3 = 2, LSB first
        tbl[8]  = {6'b110_111, 2'b00};
        tbl[9]  = {6'b010_110, 2'b11};
        tbl[10] = {6'b100_110, 2'b00};
        tbl[11] = {6'b000_110, 2'b00};
        // Serial 3-7 = 12 mod 16, borrow out
        tbl[12] = {6'b110_111, 2'b00};
        tbl[13] = {6'b110_110, 2'b00};
        tbl[14] = {6'b010_110, 2'b11};
        tbl[15] = {6'b000_110, 2'b11};

        rst_n = 1'b0;
        bus.a = 0; bus.b = 0; bus.c = 0; bus.en = 0; bus.ser = 0; bus.sof = 0;
        bus0.a = 0; bus0.b = 0; bus0.c = 0; bus0.en = 0; bus0.ser = 0; bus0.sof = 0;
        #12;
        check("reset d_q", bus.d_q, 1'b0);
        check("reset bo_q", bus.bo_q, 1'b0);
        check("reset vld", bus.vld, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].en, tbl[i].ser, tbl[i].sof,
                  $sformatf("vec%0d", i), ad, abo);
            check($sformatf("vec%0d table d", i), ad, tbl[i].exp_d);
            check($sformatf("vec%0d table bo", i), abo, tbl[i].exp_bo);
            if (i == 11) check("5-3 final bo_q", bus.bo_q, 1'b0);
            if (i == 15) check("3-7 final bo_q", bus.bo_q, 1'b1);
        end

        // Capture then hold with en=0
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "capture", ad, abo);
        check("capture d_q", bus.d_q, 1'b1);
        check("capture bo_q", bus.bo_q, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "hold", ad, abo);
        check("hold d_q literal", bus.d_q, 1'b1);

        // Async reset between edges; brg was 1 and must clear
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pre-reset", ad, abo);
        #3 rst_n = 1'b0;
        #1;
        check("async rst d_q", bus.d_q, 1'b0);
        check("async rst bo_q", bus.bo_q, 1'b0);
        check("async rst vld", bus.vld, 1'b0);
        bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b1; bus.ser = 1'b1; bus.sof = 1'b0; bus.en = 1'b1;
        #1;
        check("rst brg via d", bus.d, 1'b0);
        check("rst brg via bo", bus.bo, 1'b0);
        bus.a = 1'b1;
        @(posedge clk);
        #1;
        check("rst edge d_q", bus.d_q, 1'b0);
        check("rst edge vld", bus.vld, 1'b0);
        bus.en = 1'b0;
        brg_m = 1'b0; vld_m = 1'b0; dq_m = 1'b0; boq_m = 1'b0;
        sb_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "post-rst nosof", ad, abo);

        // ser switched mid-word: brg held while ser=0, then used again
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "sw sof", ad, abo);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw ser0", ad, abo);
        check("sw ser0 d literal", ad, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "sw ser1", ad, abo);
        check("sw ser1 d literal", ad, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "sof ser0", ad, abo);

        // Unregistered build tracks d/bo combinationally
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] r;
            v = i[2:0];
            bus0.a = v[2]; bus0.b = v[1]; bus0.c = v[0]; bus0.en = v[0];
            r = {1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]};
            #2;
            check($sformatf("nreg%0d d", i), bus0.d, r[0]);
            check($sformatf("nreg%0d d_q", i), bus0.d_q, bus0.d);
            check($sformatf("nreg%0d bo_q", i), bus0.bo_q, r[1]);
            $display("txn nreg%0d a=%b b=%b c=%b -> d=%b bo=%b d_q=%b bo_q=%b",
                     i, v[2], v[1], v[0], bus0.d, bus0.bo, bus0.d_q, bus0.bo_q);
            #8;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
